fdiv: RTL and testbench

- Iterative IEEE-754 single-precision divider, y = x1 / x2.
- Sits in the FPU beside the pipelined multiplier and uses the same ready/valid operation handshake.
- Computes quotient bits one or two per cycle with a restoring shift-subtract datapath, then normalises and rounds.
- Same number semantics as the multiplier: a zero exponent is treated as zero, and round-half-up on the guard bit.

---
 rtl/fpu_pkg.sv | 22 ++
 rtl/fdiv_if.sv | 11 +
 rtl/fdiv_step.sv | 19 +
 rtl/fdiv.sv | 152 +++++++++++++++
 tb/tb_fdiv.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: field widths, bias, canonical quiet NaN,
// the float field layout and the divider state / special-case encodings.
package fpu_pkg;

  localparam int          EXP_BIAS = 127;
  localparam int          EXP_W    = 8;
  localparam int          MAN_W    = 23;
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;
  localparam logic [7:0]  EXP_MAX  = 8'hFF;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } float_t;

  typedef enum logic [1:0] {IDLE, CALC, ROUND, DONE} fdiv_state_t;

  // Result class decided at accept time; SP_NONE means "use the datapath".
  typedef enum logic [1:0] {SP_NONE, SP_ZERO, SP_INF, SP_NAN} fdiv_special_t;

endpackage

// File: rtl/fdiv_if.sv
// Operation handshake for the divider: operands and ready in, result and valid out.
interface fdiv_if;
  logic [31:0] x1;
  logic [31:0] x2;
  logic        ready;
  logic        valid;
  logic [31:0] y;

  modport master (output x1, x2, ready, input valid, y);
  modport slave  (input x1, x2, ready, output valid, y);
endinterface

// File: rtl/fdiv_step.sv
// One restoring division step: compare, conditionally subtract, shift left.
module fdiv_step (
  input  logic [25:0] rem,
  input  logic [23:0] div,
  output logic [25:0] rem_next,
  output logic        q_bit
);
  logic [25:0] sub;
  logic [25:0] kept;

  // Quotient bit is 1 when the divisor fits; the remainder after the
  // subtract is below the divisor, so the doubled value still fits 26 bits.
  always_comb begin
    q_bit    = (rem >= {2'b00, div});
    sub      = rem - {2'b00, div};
    kept     = q_bit ? sub : rem;
    rem_next = kept << 1;
  end
endmodule

// File: rtl/fdiv.sv
// Iterative single-precision divider y = x1 / x2 (restoring, BITS_PER_CYCLE
// quotient bits per cycle). Optional IEEE inf/NaN decoding: FDIV_NAN_EN.
module fdiv
  import fpu_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic  clk,
  input  logic  rstn,
  fdiv_if.slave bus
);
  localparam int         ITER = 26 / BITS_PER_CYCLE;
  localparam logic [4:0] LAST = 5'(ITER - 1);

  fdiv_state_t   state_reg;
  fdiv_special_t special_reg;
  logic          sign_reg;
  logic [9:0]    exp_base_reg;
  logic [23:0]   div_reg;
  logic [25:0]   rem_reg;
  logic [25:0]   q_reg;
  logic [4:0]    cnt_reg;
  logic [31:0]   y_reg;
  logic          valid_reg;

  float_t        a;
  float_t        b;
  fdiv_special_t special_in;

  // Classify the operands at accept time so ROUND only has to pick a result.
  always_comb begin
    a          = float_t'(bus.x1);
    b          = float_t'(bus.x2);
    special_in = SP_NONE;
`ifdef FDIV_NAN_EN
    if ((a.exp == EXP_MAX && a.man != '0) || (b.exp == EXP_MAX && b.man != '0) ||
        (a.exp == EXP_MAX && b.exp == EXP_MAX) || (a.exp == '0 && b.exp == '0))
      special_in = SP_NAN;
    else if (a.exp == EXP_MAX) special_in = SP_INF;
    else if (b.exp == EXP_MAX) special_in = SP_ZERO;
    else if (a.exp == '0)      special_in = SP_ZERO;
    else if (b.exp == '0)      special_in = SP_INF;
`else
    if (a.exp == '0)      special_in = SP_ZERO;
    else if (b.exp == '0) special_in = SP_INF;
`endif
  end

  // Chain of restoring steps; stage 0 yields the most significant new bit.
  logic [BITS_PER_CYCLE:0][25:0] rem_chain;
  logic [BITS_PER_CYCLE-1:0]     q_bits;
  logic [25:0]                   q_next;

  assign rem_chain[0] = rem_reg;
  assign q_next       = {q_reg[25-BITS_PER_CYCLE:0], q_bits};

  generate
    for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_step
      fdiv_step u_step (
        .rem      (rem_chain[gi]),
        .div      (div_reg),
        .rem_next (rem_chain[gi+1]),
        .q_bit    (q_bits[BITS_PER_CYCLE-1-gi])
      );
    end
  endgenerate

  logic [22:0] mant;
  logic [22:0] mant_rnd;
  logic        guard;
  logic        carry;
  logic [9:0]  exp_fin;
  logic [31:0] result;

  // Normalise the 26-bit quotient, round half-up on the guard bit and pick
  // the final encoding; the exponent is treated as a 10-bit two's complement.
  always_comb begin
    if (q_reg[25]) begin
      mant  = q_reg[24:2];
      guard = q_reg[1];
    end else begin
      mant  = q_reg[23:1];
      guard = q_reg[0];
    end
    carry    = guard & (&mant);
    mant_rnd = mant + {22'b0, guard};
    exp_fin  = exp_base_reg - {9'b0, ~q_reg[25]} + {9'b0, carry};
    result   = {sign_reg, 31'b0};
    case (special_reg)
      SP_ZERO: result = {sign_reg, 31'b0};
      SP_INF:  result = {sign_reg, EXP_MAX, 23'b0};
      SP_NAN:  result = QNAN;
      default: begin
        if (exp_fin[9] || exp_fin == '0)
          result = {sign_reg, 31'b0};
        else if (exp_fin[8] || (&exp_fin[7:0]))
          result = {sign_reg, EXP_MAX, 23'b0};
        else
          result = {sign_reg, exp_fin[7:0], mant_rnd};
      end
    endcase
  end

  // Control FSM and datapath registers. valid is registered off DONE, so the
  // pulse appears in the cycle after DONE (ITER+2 edges after accept) while
  // the FSM is already back in IDLE and able to accept the next operation.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg    <= IDLE;
      special_reg  <= SP_NONE;
      sign_reg     <= 1'b0;
      exp_base_reg <= '0;
      div_reg      <= '0;
      rem_reg      <= '0;
      q_reg        <= '0;
      cnt_reg      <= '0;
      y_reg        <= '0;
      valid_reg    <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      case (state_reg)
        IDLE: if (bus.ready) begin
          special_reg  <= special_in;
          sign_reg     <= a.sign ^ b.sign;
          exp_base_reg <= {2'b00, a.exp} - {2'b00, b.exp} + 10'(EXP_BIAS);
          rem_reg      <= {2'b00, 1'b1, a.man};
          div_reg      <= {1'b1, b.man};
          q_reg        <= '0;
          cnt_reg      <= '0;
          state_reg    <= CALC;
        end
        CALC: begin
          rem_reg <= rem_chain[BITS_PER_CYCLE];
          q_reg   <= q_next;
          cnt_reg <= cnt_reg + 5'd1;
          if (cnt_reg == LAST) state_reg <= ROUND;
        end
        ROUND: begin
          y_reg     <= result;
          state_reg <= DONE;
        end
        default: begin
          valid_reg <= 1'b1;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.y     = y_reg;
  assign bus.valid = valid_reg;
endmodule

// File: tb/tb_fdiv.sv
// Testbench for fdiv: runs a 1-bit/cycle and a 2-bit/cycle divider side by
// side against an integer-arithmetic reference model.
module tb_fdiv;
  logic clk  = 1'b0;
  logic rstn = 1'b0;

  fdiv_if bus1 ();
  fdiv_if bus2 ();

  fdiv #(.BITS_PER_CYCLE(1)) dut1 (.clk(clk), .rstn(rstn), .bus(bus1));
  fdiv #(.BITS_PER_CYCLE(2)) dut2 (.clk(clk), .rstn(rstn), .bus(bus2));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // Reference: exact integer quotient, then the rounding/exponent rules.
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    logic   s;
    int     e1, e2, e, eadj;
    longint m1, m2, q, man, g, sum;
    bit     a_nan, b_nan, a_inf, b_inf;
    s  = a[31] ^ b[31];
    e1 = int'(a[30:23]);
    e2 = int'(b[30:23]);
    a_nan = (e1 == 255) && (a[22:0] != 0);
    b_nan = (e2 == 255) && (b[22:0] != 0);
    a_inf = (e1 == 255) && (a[22:0] == 0);
    b_inf = (e2 == 255) && (b[22:0] == 0);
`ifdef FDIV_NAN_EN
    if (a_nan || b_nan || (a_inf && b_inf) || (e1 == 0 && e2 == 0)) return 32'h7FC00000;
    if (a_inf) return {s, 8'hFF, 23'b0};
    if (b_inf) return {s, 31'b0};
`else
    if (a_nan || b_nan || a_inf || b_inf) begin end
`endif
    if (e1 == 0) return {s, 31'b0};
    if (e2 == 0) return {s, 8'hFF, 23'b0};
    m1 = longint'(a[22:0]) + (64'sd1 <<< 23);
    m2 = longint'(b[22:0]) + (64'sd1 <<< 23);
    q  = (m1 <<< 25) / m2;
    if (q >= (64'sd1 <<< 25)) begin
      man = (q >>> 2) & 64'h7FFFFF; g = (q >>> 1) & 1; eadj = 0;
    end else begin
      man = (q >>> 1) & 64'h7FFFFF; g = q & 1; eadj = -1;
    end
    sum = (64'sd1 <<< 23) + man + g;
    if (sum >= (64'sd1 <<< 24)) begin
      man = 0; eadj = eadj + 1;
    end else begin
      man = sum - (64'sd1 <<< 23);
    end
    e = e1 - e2 + 127 + eadj;
    if (e <= 0)   return {s, 31'b0};
    if (e >= 255) return {s, 8'hFF, 23'b0};
    return {s, 8'(e), 23'(man)};
  endfunction

  task automatic scramble();
    bus1.x1 = $urandom; bus1.x2 = $urandom;
    bus2.x1 = $urandom; bus2.x2 = $urandom;
  endtask

  // One operation on both dividers; inputs are scrambled during CALC.
  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_y);
    logic [31:0] y1, y2;
    int lat1, lat2, hi1, hi2;
    y1 = 'x; y2 = 'x; lat1 = -1; lat2 = -1; hi1 = 0; hi2 = 0;
    @(negedge clk);
    bus1.x1 = a; bus1.x2 = b; bus1.ready = 1'b1;
    bus2.x1 = a; bus2.x2 = b; bus2.ready = 1'b1;
    @(posedge clk); #1;
    bus1.ready = 1'b0; bus2.ready = 1'b0;
    scramble();
    for (int n = 1; n <= 32; n++) begin
      @(posedge clk); #1;
      if (n == 5) scramble();
      if (bus1.valid) begin hi1++; if (lat1 < 0) begin lat1 = n; y1 = bus1.y; end end
      if (bus2.valid) begin hi2++; if (lat2 < 0) begin lat2 = n; y2 = bus2.y; end end
    end
    check({name, ".y1"}, y1, exp_y);
    check({name, ".y2"}, y2, exp_y);
    check({name, ".lat1"}, 32'(lat1), 32'd28);
    check({name, ".lat2"}, 32'(lat2), 32'd15);
    check({name, ".pulse1"}, 32'(hi1), 32'd1);
    check({name, ".pulse2"}, 32'(hi2), 32'd1);
    check({name, ".hold1"}, bus1.y, exp_y);
    $display("op %s: %h / %h -> y1=%h (lat %0d) y2=%h (lat %0d) ref=%h",
             name, a, b, y1, lat1, y2, lat2, exp_y);
  endtask

  initial begin
    int vpos[3];
    int nv;
    logic [31:0] vy[3];
    logic [31:0] ra, rb;

    bus1.x1 = '0; bus1.x2 = '0; bus1.ready = 1'b0;
    bus2.x1 = '0; bus2.x2 = '0; bus2.ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.valid1", 32'(bus1.valid), 32'd0);
    check("rst.y1", bus1.y, 32'd0);
    check("rst.valid2", 32'(bus2.valid), 32'd0);
    check("rst.y2", bus2.y, 32'd0);
    @(negedge clk); rstn = 1'b1;

    run_op("six_by_two", 32'h40C00000, 32'h40000000, 32'h40400000);
    run_op("one_third",  32'h3F800000, 32'h40400000, 32'h3EAAAAAB);
    run_op("div_zero",   32'hBF800000, 32'h00000000, 32'hFF800000);
    run_op("zero_num",   32'h80000000, 32'h40A00000, 32'h80000000);
    run_op("overflow",   32'h7F000000, 32'h3E800000, 32'h7F800000);
    run_op("underflow",  32'h00800000, 32'h40000000, 32'h00000000);
`ifdef FDIV_NAN_EN
    run_op("inf_inf",    32'h7F800000, 32'h7F800000, 32'h7FC00000);
`else
    run_op("inf_inf",    32'h7F800000, 32'h7F800000, 32'h3F800000);
`endif

    // ready held high: back-to-back operations on the 1-bit divider
    for (int i = 0; i < 3; i++) begin vpos[i] = -1; vy[i] = 'x; end
    nv = 0;
    @(negedge clk);
    bus1.x1 = 32'h40C00000; bus1.x2 = 32'h40000000; bus1.ready = 1'b1;
    @(posedge clk); #1;
    for (int n = 1; n <= 100 && nv < 3; n++) begin
      @(posedge clk); #1;
      if (bus1.valid) begin
        vpos[nv] = n; vy[nv] = bus1.y; nv++;
        if (nv == 3) bus1.ready = 1'b0;
      end
    end
    bus1.ready = 1'b0;
    check("b2b.first", 32'(vpos[0]), 32'd28);
    check("b2b.gap1", 32'(vpos[1] - vpos[0]), 32'd29);
    check("b2b.gap2", 32'(vpos[2] - vpos[1]), 32'd29);
    for (int i = 0; i < 3; i++) check("b2b.y", vy[i], 32'h40400000);
    $display("op back_to_back: valid at edges %0d %0d %0d", vpos[0], vpos[1], vpos[2]);
    repeat (35) @(posedge clk);

    // reset during CALC iteration 10
    @(negedge clk);
    bus1.x1 = 32'h40C00000; bus1.x2 = 32'h40000000; bus1.ready = 1'b1;
    bus2.x1 = 32'h40C00000; bus2.x2 = 32'h40000000; bus2.ready = 1'b1;
    @(posedge clk); #1;
    bus1.ready = 1'b0; bus2.ready = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    check("abort.valid1", 32'(bus1.valid), 32'd0);
    check("abort.y1", bus1.y, 32'd0);
    check("abort.valid2", 32'(bus2.valid), 32'd0);
    check("abort.y2", bus2.y, 32'd0);
    $display("op reset_abort: rstn asserted during CALC");
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    run_op("after_rst", 32'h40000000, 32'h3F800000, 32'h40000000);

    // randomized operands, half with exponents near the bias
    for (int i = 0; i < 24; i++) begin
      ra = $urandom; rb = $urandom;
      if (i % 2 == 0) begin
        ra[30:23] = 8'($urandom_range(100, 154));
        rb[30:23] = 8'($urandom_range(100, 154));
      end
      run_op($sformatf("rand%0d", i), ra, rb, ref_div(ra, rb));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
